// File: rtl/decode_stage.sv
// decode_stage: RV32 instruction decode with a single-entry registered output.
// Optional feature: define DECODE_ILLEGAL_EN to add the registered illegal_o flag.
// The aluop encoding below (Add, Sleft, Branch, Funct) matches core_pkg.

module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [1:0]      aluop_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic            itype_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] pc_o,
    output logic            branch_o,
    output logic            jal_o,
    output logic            jalr_o,
    output logic            load_o,
    output logic            store_o,
    output logic            regwrite_o,
`ifdef DECODE_ILLEGAL_EN
    output logic            illegal_o,
`endif
    output logic            use_imm_o
);

    typedef enum logic [1:0] {
        ALU_ADD    = 2'd0,
        ALU_SLEFT  = 2'd1,
        ALU_BRANCH = 2'd2,
        ALU_FUNCT  = 2'd3
    } aluop_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic            valid_q;
    logic            accept;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    aluop_e          aluop_dec;
    logic            itype_dec;
    logic            branch_dec;
    logic            jal_dec;
    logic            jalr_dec;
    logic            load_dec;
    logic            store_dec;
    logic            use_imm_dec;
    logic            regwrite_raw;
    logic            regwrite_dec;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rd     = instr_i[11:7];

    // Only the ready path is combinational; a flush kills the incoming word.
    assign ready_o = ~valid_q | ready_i;
    assign accept  = valid_i & ready_o & ~flush_i;
    assign valid_o = valid_q;

    // Opcode to control flags, ALU operation and format-specific immediate.
    always_comb begin
        aluop_dec    = ALU_ADD;
        itype_dec    = 1'b0;
        branch_dec   = 1'b0;
        jal_dec      = 1'b0;
        jalr_dec     = 1'b0;
        load_dec     = 1'b0;
        store_dec    = 1'b0;
        use_imm_dec  = 1'b0;
        regwrite_raw = 1'b0;
        imm32        = 32'd0;
        case (opcode)
            OPC_OP: begin
                aluop_dec    = ALU_FUNCT;
                regwrite_raw = 1'b1;
            end
            OPC_OP_IMM: begin
                aluop_dec    = ALU_FUNCT;
                itype_dec    = 1'b1;
                use_imm_dec  = 1'b1;
                regwrite_raw = 1'b1;
                imm32        = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_LOAD: begin
                load_dec     = 1'b1;
                use_imm_dec  = 1'b1;
                regwrite_raw = 1'b1;
                imm32        = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_STORE: begin
                store_dec    = 1'b1;
                use_imm_dec  = 1'b1;
                imm32        = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_BRANCH: begin
                aluop_dec    = ALU_BRANCH;
                branch_dec   = 1'b1;
                imm32        = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OPC_JAL: begin
                jal_dec      = 1'b1;
                regwrite_raw = 1'b1;
                imm32        = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                instr_i[20], instr_i[30:21], 1'b0};
            end
            OPC_JALR: begin
                jalr_dec     = 1'b1;
                use_imm_dec  = 1'b1;
                regwrite_raw = 1'b1;
                imm32        = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_LUI: begin
                aluop_dec    = ALU_SLEFT;
                use_imm_dec  = 1'b1;
                regwrite_raw = 1'b1;
                imm32        = {instr_i[31:12], 12'd0};
            end
            OPC_AUIPC: begin
                use_imm_dec  = 1'b1;
                regwrite_raw = 1'b1;
                imm32        = {instr_i[31:12], 12'd0};
            end
            default: begin
                aluop_dec    = ALU_ADD;
            end
        endcase
    end

    // Sign-extend the 32-bit immediate to the datapath width.
    always_comb begin
        imm_ext = {{(XLEN - 31){imm32[31]}}, imm32[30:0]};
    end

`ifdef DECODE_ILLEGAL_EN
    logic illegal_dec;
    logic known_opcode;

    // Flags unknown opcodes, non-32-bit encodings and bad OP funct7/funct3 pairs.
    always_comb begin
        known_opcode = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: known_opcode = 1'b1;
            default: known_opcode = 1'b0;
        endcase
        illegal_dec = ~known_opcode || (instr_i[1:0] != 2'b11);
        if (opcode == OPC_OP) begin
            if (funct7 == 7'h20) begin
                if ((funct3 != 3'd0) && (funct3 != 3'd5)) begin
                    illegal_dec = 1'b1;
                end
            end else if (funct7 != 7'h00) begin
                illegal_dec = 1'b1;
            end
        end
        regwrite_dec = regwrite_raw & (rd != 5'd0) & ~illegal_dec;
    end
`else
    // Writes to x0 are suppressed so downstream never sees a dead write.
    always_comb begin
        regwrite_dec = regwrite_raw & (rd != 5'd0);
    end
`endif

    // Output valid: flush wins, then accept, then downstream transfer drains.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Decoded payload loads only on accept, so it holds steady during a stall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aluop_o    <= 2'd0;
            funct3_o   <= 3'd0;
            funct7_o   <= 7'd0;
            itype_o    <= 1'b0;
            rs1_o      <= 5'd0;
            rs2_o      <= 5'd0;
            rd_o       <= 5'd0;
            imm_o      <= '0;
            pc_o       <= '0;
            branch_o   <= 1'b0;
            jal_o      <= 1'b0;
            jalr_o     <= 1'b0;
            load_o     <= 1'b0;
            store_o    <= 1'b0;
            regwrite_o <= 1'b0;
            use_imm_o  <= 1'b0;
`ifdef DECODE_ILLEGAL_EN
            illegal_o  <= 1'b0;
`endif
        end else if (accept) begin
            aluop_o    <= aluop_dec;
            funct3_o   <= funct3;
            funct7_o   <= funct7;
            itype_o    <= itype_dec;
            rs1_o      <= instr_i[19:15];
            rs2_o      <= instr_i[24:20];
            rd_o       <= rd;
            imm_o      <= imm_ext;
            pc_o       <= pc_i;
            branch_o   <= branch_dec;
            jal_o      <= jal_dec;
            jalr_o     <= jalr_dec;
            load_o     <= load_dec;
            store_o    <= store_dec;
            regwrite_o <= regwrite_dec;
            use_imm_o  <= use_imm_dec;
`ifdef DECODE_ILLEGAL_EN
            illegal_o  <= illegal_dec;
`endif
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage handshake, decode and reset.
// Build with DECODE_ILLEGAL_EN defined to also exercise illegal_o.

module tb_decode_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [1:0]  aluop_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic        itype_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;
    logic [31:0] imm_o;
    logic [31:0] pc_o;
    logic        branch_o;
    logic        jal_o;
    logic        jalr_o;
    logic        load_o;
    logic        store_o;
    logic        regwrite_o;
    logic        use_imm_o;
`ifdef DECODE_ILLEGAL_EN
    logic        illegal_o;
`endif

    int errors = 0;
    int checks = 0;

    // {branch, jal, jalr, load, store, regwrite, use_imm, itype}
    logic [7:0] flags;
    assign flags = {branch_o, jal_o, jalr_o, load_o, store_o, regwrite_o, use_imm_o, itype_o};

    decode_stage #(.XLEN(32)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .instr_i    (instr_i),
        .pc_i       (pc_i),
        .flush_i    (flush_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .aluop_o    (aluop_o),
        .funct3_o   (funct3_o),
        .funct7_o   (funct7_o),
        .itype_o    (itype_o),
        .rs1_o      (rs1_o),
        .rs2_o      (rs2_o),
        .rd_o       (rd_o),
        .imm_o      (imm_o),
        .pc_o       (pc_o),
        .branch_o   (branch_o),
        .jal_o      (jal_o),
        .jalr_o     (jalr_o),
        .load_o     (load_o),
        .store_o    (store_o),
        .regwrite_o (regwrite_o),
`ifdef DECODE_ILLEGAL_EN
        .illegal_o  (illegal_o),
`endif
        .use_imm_o  (use_imm_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        valid_i = v;
        instr_i = instr;
        pc_i    = pc;
    endtask

    initial begin
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        drive(1'b0, 32'h0, 32'h0);

        // Reset state
        #1;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_flags", {24'd0, flags}, 32'd0);
        check("rst_imm", imm_o, 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;

        // addi x1, x0, 5
        drive(1'b1, 32'h00500093, 32'h100);
        tick();
        check("addi_valid", {31'd0, valid_o}, 32'd1);
        check("addi_aluop", {30'd0, aluop_o}, 32'd3);
        check("addi_rd", {27'd0, rd_o}, 32'd1);
        check("addi_imm", imm_o, 32'd5);
        check("addi_flags", {24'd0, flags}, 32'b0000_0111);
        check("addi_pc", pc_o, 32'h100);

        // sub x2, x1, x2 then jal x1, 12 back to back
        drive(1'b1, 32'h40208133, 32'h104);
        tick();
        check("sub_valid", {31'd0, valid_o}, 32'd1);
        check("sub_funct7", {25'd0, funct7_o}, 32'h20);
        check("sub_aluop", {30'd0, aluop_o}, 32'd3);
        check("sub_regs", {17'd0, rs1_o, rs2_o, rd_o}, {17'd0, 5'd1, 5'd2, 5'd2});
        check("sub_flags", {24'd0, flags}, 32'b0000_0100);
        drive(1'b1, 32'h00C000EF, 32'h108);
        tick();
        check("jal_valid", {31'd0, valid_o}, 32'd1);
        check("jal_imm", imm_o, 32'd12);
        check("jal_flags", {24'd0, flags}, 32'b0100_0100);
        check("jal_aluop", {30'd0, aluop_o}, 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("drain_valid", {31'd0, valid_o}, 32'd0);

        // lui x5, 0x12345 then a 3-cycle stall with a store waiting
        drive(1'b1, 32'h123452B7, 32'h200);
        tick();
        check("lui_imm", imm_o, 32'h12345000);
        check("lui_aluop", {30'd0, aluop_o}, 32'd1);
        ready_i = 1'b0;
        drive(1'b1, 32'h0020A423, 32'h204);
        #1;
        check("stall_ready", {31'd0, ready_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'd0, valid_o}, 32'd1);
            check("stall_imm", imm_o, 32'h12345000);
            check("stall_pc", pc_o, 32'h200);
            check("stall_flags", {24'd0, flags}, 32'b0000_0110);
        end
        ready_i = 1'b1;
        #1;
        check("release_ready", {31'd0, ready_o}, 32'd1);
        tick();
        check("sw_valid", {31'd0, valid_o}, 32'd1);
        check("sw_imm", imm_o, 32'd8);
        check("sw_flags", {24'd0, flags}, 32'b0000_1010);
        check("sw_pc", pc_o, 32'h204);

        // Flush with a held instruction and an incoming one
        ready_i = 1'b0;
        flush_i = 1'b1;
        drive(1'b1, 32'hFE000EE3, 32'h300);
        tick();
        check("flush_valid", {31'd0, valid_o}, 32'd0);
        check("flush_dropped_pc", pc_o, 32'h204);
        flush_i = 1'b0;
        ready_i = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("flush_after", {31'd0, valid_o}, 32'd0);

        // beq x0, x0, -4
        drive(1'b1, 32'hFE000EE3, 32'h304);
        tick();
        check("beq_aluop", {30'd0, aluop_o}, 32'd2);
        check("beq_imm", imm_o, 32'hFFFFFFFC);
        check("beq_flags", {24'd0, flags}, 32'b1000_0000);

        // addi x0, x0, 0: write to x0 suppressed
        drive(1'b1, 32'h00000013, 32'h308);
        tick();
        check("nop_flags", {24'd0, flags}, 32'b0000_0011);

        // All-zero word: unrecognised opcode
        drive(1'b1, 32'h00000000, 32'h30C);
        tick();
        check("zero_valid", {31'd0, valid_o}, 32'd1);
        check("zero_flags", {24'd0, flags}, 32'd0);
        check("zero_aluop", {30'd0, aluop_o}, 32'd0);
`ifdef DECODE_ILLEGAL_EN
        check("zero_illegal", {31'd0, illegal_o}, 32'd1);
`endif

        // OP with funct7 = 0x01
        drive(1'b1, 32'h02208133, 32'h310);
        tick();
        check("f7_funct7", {25'd0, funct7_o}, 32'h01);
`ifdef DECODE_ILLEGAL_EN
        check("f7_illegal", {31'd0, illegal_o}, 32'd1);
        check("f7_flags", {24'd0, flags}, 32'd0);
`else
        check("f7_flags", {24'd0, flags}, 32'b0000_0100);
`endif

        // Asynchronous reset in the middle of a stall
        drive(1'b1, 32'h00500093, 32'h400);
        tick();
        ready_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        check("mid_rst_rd", {27'd0, rd_o}, 32'd0);
        check("mid_rst_imm", imm_o, 32'd0);
        check("mid_rst_ready", {31'd0, ready_o}, 32'd1);
        rst_ni = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
